branch_history_table: RTL and testbench

// - Branch-prediction table driven by the pipeline interface controller's bht_op stream.
// - IF side: combinational lookup of the fetch PC. Returns a take/target prediction, which
//   the pipeline carries to EX as ex_bht_take.
// - EX side: applies SET/INC/DEC updates at the clock edge. Also counts predictor
//   hit/miss events for debug readout.
// - Sits beside the PC register; the PC next-value mux consumes if_take/if_target.

---
 rtl/branch_history_table_pkg.sv | 25 ++
 rtl/branch_history_table_if.sv | 41 ++++
 rtl/branch_history_table_sat_counter.sv | 38 +++
 rtl/branch_history_table.sv | 137 +++++++++++++
 tb/tb_branch_history_table.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_history_table_pkg.sv
// Shared definitions for the branch history table.
// Contents:
//   - default widths (PC word-address width, table index width)
//   - bht_op encodings driven by the pipeline interface controller
//   - 2-bit prediction counter encodings
package branch_history_table_pkg;

    // Stand-in for the core-wide instruction-memory word-address width.
    localparam int BHT_ADDR_NBIT_DEF = 12;
    localparam int BHT_IDX_NBIT      = 3;
    localparam int BHT_OP_NBIT       = 3;

    // Controller op codes. Codes 4..7 are undefined and act as NOP.
    localparam logic [BHT_OP_NBIT-1:0] BHT_OP_NOP = 3'd0;
    localparam logic [BHT_OP_NBIT-1:0] BHT_OP_SET = 3'd1;
    localparam logic [BHT_OP_NBIT-1:0] BHT_OP_INC = 3'd2;
    localparam logic [BHT_OP_NBIT-1:0] BHT_OP_DEC = 3'd3;

    // Prediction counter states; bit 1 set means "predict taken".
    localparam logic [1:0] BHT_CNT_SN = 2'd0;
    localparam logic [1:0] BHT_CNT_WN = 2'd1;
    localparam logic [1:0] BHT_CNT_WT = 2'd2;
    localparam logic [1:0] BHT_CNT_ST = 2'd3;

endpackage

// File: rtl/branch_history_table_if.sv
// Pipeline-facing bundle of the branch history table.
// Ports (all signals, direction given for the slave = table side):
//   if_pc     in   fetch PC to look up
//   if_take   out  predict taken
//   if_target out  predicted target (0 on miss)
//   ex_pc     in   PC of the branch in EX
//   ex_target in   resolved target in EX
//   bht_op    in   NOP/SET/INC/DEC
//   bht_clr   in   synchronous flush of all entries
//   dbp_hit   in   prediction-correct event
//   dbp_miss  in   misprediction event
//   hit_cnt   out  saturating count of dbp_hit cycles
//   miss_cnt  out  saturating count of dbp_miss cycles
interface branch_history_table_if
    import branch_history_table_pkg::*;
#(
    parameter int ADDR_NBIT = BHT_ADDR_NBIT_DEF,
    parameter int CNT_NBIT  = 32
);
    logic [ADDR_NBIT-1:0]   if_pc;
    logic                   if_take;
    logic [ADDR_NBIT-1:0]   if_target;
    logic [ADDR_NBIT-1:0]   ex_pc;
    logic [ADDR_NBIT-1:0]   ex_target;
    logic [BHT_OP_NBIT-1:0] bht_op;
    logic                   bht_clr;
    logic                   dbp_hit;
    logic                   dbp_miss;
    logic [CNT_NBIT-1:0]    hit_cnt;
    logic [CNT_NBIT-1:0]    miss_cnt;

    modport master (
        output if_pc, ex_pc, ex_target, bht_op, bht_clr, dbp_hit, dbp_miss,
        input  if_take, if_target, hit_cnt, miss_cnt
    );

    modport slave (
        input  if_pc, ex_pc, ex_target, bht_op, bht_clr, dbp_hit, dbp_miss,
        output if_take, if_target, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_history_table_sat_counter.sv
// Saturating up/down counter used for the predictor statistics.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears to 0)
//   up_i        count up by 1, holds at all-ones
//   dn_i        count down by 1, holds at 0
//   cnt_o       current count
// up_i and dn_i together cancel out.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_i,
    input  logic             dn_i,
    output logic [WIDTH-1:0] cnt_o
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (up_i && !dn_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else if (dn_i && !up_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/branch_history_table.sv
// Direct-mapped branch history table.
// Fetch side looks up if_pc combinationally (no bypass of same-cycle updates);
// EX side applies SET/INC/DEC at the clock edge; bht_clr invalidates every
// entry in one cycle and overrides any same-cycle update. Two saturating
// counters track predictor hit/miss events.
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   bus    branch_history_table_if.slave (lookup, update, statistics)
module branch_history_table
    import branch_history_table_pkg::*;
#(
    parameter int ADDR_NBIT = BHT_ADDR_NBIT_DEF,
    parameter int IDX_NBIT  = BHT_IDX_NBIT,
    parameter int CNT_NBIT  = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    branch_history_table_if.slave  bus
);
    localparam int ENTRIES  = 1 << IDX_NBIT;
    localparam int TAG_NBIT = ADDR_NBIT - IDX_NBIT;

    function automatic logic [1:0] cnt2_inc(input logic [1:0] c);
        return (c == BHT_CNT_ST) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] cnt2_dec(input logic [1:0] c);
        return (c == BHT_CNT_SN) ? c : c - 2'd1;
    endfunction

    // Table held in flops so lookup is asynchronous and flush is single-cycle.
    logic                 valid_q [ENTRIES];
    logic                 valid_d [ENTRIES];
    logic [TAG_NBIT-1:0]  tag_q   [ENTRIES];
    logic [TAG_NBIT-1:0]  tag_d   [ENTRIES];
    logic [ADDR_NBIT-1:0] tgt_q   [ENTRIES];
    logic [ADDR_NBIT-1:0] tgt_d   [ENTRIES];
    logic [1:0]           cnt_q   [ENTRIES];
    logic [1:0]           cnt_d   [ENTRIES];

    // Fetch-side lookup
    logic [IDX_NBIT-1:0] lk_idx;
    logic [TAG_NBIT-1:0] lk_tag;
    logic                lk_hit;

    assign lk_idx = bus.if_pc[IDX_NBIT-1:0];
    assign lk_tag = bus.if_pc[ADDR_NBIT-1:IDX_NBIT];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign bus.if_take   = lk_hit && cnt_q[lk_idx][1];
    assign bus.if_target = lk_hit ? tgt_q[lk_idx] : '0;

    // EX-side update
    logic [IDX_NBIT-1:0] ex_idx;
    logic [TAG_NBIT-1:0] ex_tag;
    logic                ex_hit;

    assign ex_idx = bus.ex_pc[IDX_NBIT-1:0];
    assign ex_tag = bus.ex_pc[ADDR_NBIT-1:IDX_NBIT];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (bus.bht_clr) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else begin
            case (bus.bht_op)
                BHT_OP_SET: begin
                    valid_d[ex_idx] = 1'b1;
                    tag_d[ex_idx]   = ex_tag;
                    tgt_d[ex_idx]   = bus.ex_target;
                    cnt_d[ex_idx]   = BHT_CNT_ST;
                end
                BHT_OP_INC: begin
                    tgt_d[ex_idx] = bus.ex_target;
                    if (ex_hit) begin
                        cnt_d[ex_idx] = cnt2_inc(cnt_q[ex_idx]);
                    end else begin
                        // A taken branch not in the table is allocated weakly taken.
                        valid_d[ex_idx] = 1'b1;
                        tag_d[ex_idx]   = ex_tag;
                        cnt_d[ex_idx]   = BHT_CNT_WT;
                    end
                end
                BHT_OP_DEC: begin
                    if (ex_hit) begin
                        cnt_d[ex_idx] = cnt2_dec(cnt_q[ex_idx]);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '{default: 1'b0};
            tag_q   <= '{default: '0};
            tgt_q   <= '{default: '0};
            cnt_q   <= '{default: BHT_CNT_WN};
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Statistics
    logic [CNT_NBIT-1:0] hit_cnt;
    logic [CNT_NBIT-1:0] miss_cnt;

    sat_counter #(.WIDTH(CNT_NBIT)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .up_i  (bus.dbp_hit),
        .dn_i  (1'b0),
        .cnt_o (hit_cnt)
    );

    sat_counter #(.WIDTH(CNT_NBIT)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .up_i  (bus.dbp_miss),
        .dn_i  (1'b0),
        .cnt_o (miss_cnt)
    );

    assign bus.hit_cnt  = hit_cnt;
    assign bus.miss_cnt = miss_cnt;
endmodule

// File: tb/tb_branch_history_table.sv
module tb_branch_history_table;
    import branch_history_table_pkg::*;

    localparam int AW = 12;
    localparam int CW = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    branch_history_table_if #(.ADDR_NBIT(AW), .CNT_NBIT(CW)) bus();

    branch_history_table #(.ADDR_NBIT(AW), .IDX_NBIT(3), .CNT_NBIT(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: 8 entries, counters as plain integers 0..3.
    bit          m_valid [8];
    int unsigned m_tag   [8];
    int unsigned m_tgt   [8];
    int          m_cnt   [8];
    longint      m_hits;
    longint      m_miss;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
        end
        m_hits = 0;
        m_miss = 0;
    endfunction

    function automatic bit model_take(int unsigned pc);
        int unsigned i = pc % 8;
        return m_valid[i] && (m_tag[i] == pc / 8) && (m_cnt[i] >= 2);
    endfunction

    function automatic int unsigned model_target(int unsigned pc);
        int unsigned i = pc % 8;
        return (m_valid[i] && (m_tag[i] == pc / 8)) ? m_tgt[i] : 0;
    endfunction

    // Applies one clock edge worth of behaviour using the currently driven inputs.
    function automatic void model_edge();
        int unsigned pc  = bus.ex_pc;
        int unsigned i   = pc % 8;
        int unsigned t   = pc / 8;
        bit          hit = m_valid[i] && (m_tag[i] == t);
        longint      maxc = (longint'(1) << CW) - 1;
        if (bus.dbp_hit  && m_hits < maxc) m_hits++;
        if (bus.dbp_miss && m_miss < maxc) m_miss++;
        if (bus.bht_clr) begin
            for (int k = 0; k < 8; k++) m_valid[k] = 0;
        end else if (bus.bht_op == 3'd1) begin
            m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = bus.ex_target; m_cnt[i] = 3;
        end else if (bus.bht_op == 3'd2) begin
            m_tgt[i] = bus.ex_target;
            if (hit) m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
            else begin m_valid[i] = 1; m_tag[i] = t; m_cnt[i] = 2; end
        end else if (bus.bht_op == 3'd3) begin
            if (hit) m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.bht_op = BHT_OP_NOP; bus.bht_clr = 1'b0;
        bus.dbp_hit = 1'b0; bus.dbp_miss = 1'b0;
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [AW-1:0] pc, input logic [AW-1:0] tgt);
        bus.bht_op = op; bus.ex_pc = pc; bus.ex_target = tgt; bus.bht_clr = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic flush();
        idle(); bus.bht_clr = 1'b1; tick(); bus.bht_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.ex_pc = '0; bus.ex_target = '0;
        rst_n = 1'b0; model_reset();
        bus.if_pc = 12'h012;
        #3;
        checks++;
        if (bus.if_take !== 1'b0 || bus.if_target !== '0) begin
            errors++; $display("FAIL reset_lookup take=%0b tgt=%h want 0 000", bus.if_take, bus.if_target);
        end
        checks++;
        if (bus.hit_cnt !== '0 || bus.miss_cnt !== '0) begin
            errors++; $display("FAIL reset_stats hit=%0d miss=%0d want 0 0", bus.hit_cnt, bus.miss_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.if_take !== 1'b0 || bus.if_target !== '0) begin
            errors++; $display("FAIL reset_release take=%0b tgt=%h want 0 000", bus.if_take, bus.if_target);
        end
    endtask

    task automatic test_set();
        drive_op(BHT_OP_SET, 12'h012, 12'h040);
        tick();
        idle();
        bus.if_pc = 12'h012; #1;
        checks++;
        if (bus.if_take !== 1'b1 || bus.if_target !== 12'h040) begin
            errors++; $display("FAIL set_hit take=%0b tgt=%h want 1 040", bus.if_take, bus.if_target);
        end
        bus.if_pc = 12'h01A; #1;
        checks++;
        if (bus.if_take !== 1'b0 || bus.if_target !== '0) begin
            errors++; $display("FAIL set_other_tag take=%0b tgt=%h want 0 000", bus.if_take, bus.if_target);
        end
    endtask

    task automatic test_dec_sat();
        bit exp_take [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0] ops [6] = '{BHT_OP_DEC, BHT_OP_DEC, BHT_OP_DEC, BHT_OP_DEC, BHT_OP_INC, BHT_OP_INC};
        flush();
        drive_op(BHT_OP_SET, 12'h012, 12'h040);
        tick();
        bus.if_pc = 12'h012;
        for (int k = 0; k < 6; k++) begin
            drive_op(ops[k], 12'h012, 12'h040);
            tick();
            idle(); #1;
            checks++;
            if (bus.if_take !== exp_take[k] || bus.if_take !== model_take(12'h012)) begin
                errors++; $display("FAIL dec_sat step%0d take=%0b want %0b", k, bus.if_take, exp_take[k]);
            end
        end
    endtask

    task automatic test_inc_alloc();
        flush();
        drive_op(BHT_OP_INC, 12'h005, 12'h100);
        tick();
        drive_op(BHT_OP_DEC, 12'h006, 12'h200);
        tick();
        idle();
        bus.if_pc = 12'h005; #1;
        checks++;
        if (bus.if_take !== 1'b1 || bus.if_target !== 12'h100) begin
            errors++; $display("FAIL inc_alloc take=%0b tgt=%h want 1 100", bus.if_take, bus.if_target);
        end
        bus.if_pc = 12'h006; #1;
        checks++;
        if (bus.if_take !== 1'b0 || bus.if_target !== '0) begin
            errors++; $display("FAIL dec_miss take=%0b tgt=%h want 0 000", bus.if_take, bus.if_target);
        end
        // Undefined op code must leave the table alone.
        drive_op(3'd6, 12'h005, 12'h3FF);
        tick(); idle();
        bus.if_pc = 12'h005; #1;
        checks++;
        if (bus.if_take !== 1'b1 || bus.if_target !== 12'h100) begin
            errors++; $display("FAIL undef_op take=%0b tgt=%h want 1 100", bus.if_take, bus.if_target);
        end
    endtask

    task automatic test_same_cycle();
        flush();
        bus.if_pc = 12'h012;
        drive_op(BHT_OP_SET, 12'h012, 12'h040);
        #1;
        checks++;
        if (bus.if_take !== 1'b0) begin
            errors++; $display("FAIL same_cycle_pre take=%0b want 0", bus.if_take);
        end
        tick(); idle(); #1;
        checks++;
        if (bus.if_take !== 1'b1 || bus.if_target !== 12'h040) begin
            errors++; $display("FAIL same_cycle_post take=%0b tgt=%h want 1 040", bus.if_take, bus.if_target);
        end
    endtask

    task automatic test_stats_clr();
        pulse_reset();
        drive_op(BHT_OP_SET, 12'h012, 12'h040);
        tick();
        drive_op(BHT_OP_SET, 12'h005, 12'h100);
        tick();
        idle();
        bus.dbp_hit = 1'b1;
        repeat (5) tick();
        bus.dbp_miss = 1'b1;
        tick();
        idle();
        // Clear with a competing SET: the SET must be dropped.
        drive_op(BHT_OP_SET, 12'h007, 12'h0AA);
        bus.bht_clr = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.hit_cnt !== 32'd6 || bus.miss_cnt !== 32'd1) begin
            errors++; $display("FAIL stats hit=%0d miss=%0d want 6 1", bus.hit_cnt, bus.miss_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            logic [AW-1:0] pcs [3] = '{12'h012, 12'h005, 12'h007};
            bus.if_pc = pcs[k]; #1;
            checks++;
            if (bus.if_take !== 1'b0 || bus.if_target !== '0) begin
                errors++; $display("FAIL clr_lookup pc=%h take=%0b tgt=%h want 0 000", pcs[k], bus.if_take, bus.if_target);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.if_pc     = AW'($urandom_range(0, 3) * 8 + $urandom_range(0, 7));
            bus.ex_pc     = AW'($urandom_range(0, 3) * 8 + $urandom_range(0, 7));
            bus.ex_target = AW'($urandom_range(0, 4095));
            bus.bht_op    = 3'($urandom_range(0, 7));
            bus.bht_clr   = ($urandom_range(0, 24) == 0);
            bus.dbp_hit   = 1'($urandom_range(0, 1));
            bus.dbp_miss  = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (bus.if_take !== model_take(bus.if_pc) || bus.if_target !== AW'(model_target(bus.if_pc))) begin
                errors++; $display("FAIL rand_lookup n=%0d pc=%h take=%0b tgt=%h want %0b %h", n, bus.if_pc,
                                   bus.if_take, bus.if_target, model_take(bus.if_pc), model_target(bus.if_pc));
            end
            tick();
            checks++;
            if (bus.hit_cnt !== CW'(m_hits) || bus.miss_cnt !== CW'(m_miss)) begin
                errors++; $display("FAIL rand_stats n=%0d hit=%0d miss=%0d want %0d %0d", n,
                                   bus.hit_cnt, bus.miss_cnt, m_hits, m_miss);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        drive_op(BHT_OP_SET, 12'h012, 12'h040);
        bus.dbp_hit = 1'b1;
        tick();
        bus.if_pc = 12'h012; #1;
        checks++;
        if (bus.if_take !== 1'b1 || bus.hit_cnt === '0) begin
            errors++; $display("FAIL pre_async take=%0b hit=%0d want 1 nonzero", bus.if_take, bus.hit_cnt);
        end
        // Assert reset mid-cycle while an update is still being driven.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.if_take !== 1'b0 || bus.if_target !== '0 || bus.hit_cnt !== '0 || bus.miss_cnt !== '0) begin
            errors++; $display("FAIL async_reset take=%0b tgt=%h hit=%0d miss=%0d want 0 000 0 0",
                               bus.if_take, bus.if_target, bus.hit_cnt, bus.miss_cnt);
        end
        model_reset();
        idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.if_take !== 1'b0 || bus.hit_cnt !== '0) begin
            errors++; $display("FAIL after_async take=%0b hit=%0d want 0 0", bus.if_take, bus.hit_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.if_pc = '0;
        bus.ex_pc = '0;
        bus.ex_target = '0;
        idle();
        model_reset();
        test_reset();
        test_set();
        test_dec_sat();
        test_inc_alloc();
        test_same_cycle();
        test_stats_clr();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
